// File: rtl/echo_delay.sv
// Purpose: audio echo mixer; each ADC sample is summed with an attenuated sample from `delay` samples ago (circular RAM buffer), saturated, offset-binary out.
// Latency: data_valid in cycle N -> out_valid/data_out in cycle N+3; FSM returns to IDLE after cycle N+4 (5-cycle minimum spacing).
// Backpressure: none; a data_valid seen while busy is dropped and latches the sticky overrun flag. Build option: ECHO_FEEDBACK_EN (recursive echo).
module echo_delay #(
    parameter int ADDR_W = 13,
    parameter int MID    = 512
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [9:0]        data_in,
    input  logic              data_valid,
    input  logic [ADDR_W-1:0] delay,
    input  logic [1:0]        atten,
    output logic [9:0]        data_out,
    output logic              out_valid,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CALC,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] delay_q;
    logic [1:0]        atten_q;
    logic signed [10:0] x_q;

    // Echo buffer: single port, synchronous read, contents never cleared.
    logic [9:0]        mem [2**ADDR_W];
    logic [9:0]        ram_q;
    logic [9:0]        ram_wdat;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    logic signed [10:0] x_calc;
    logic signed [9:0]  m;
    logic signed [9:0]  e_shift;
    logic signed [9:0]  e;
    logic               echo_on;
    logic [11:0]        sum;
    logic [9:0]         sat;
    logic [9:0]         out_word;

`ifdef ECHO_FEEDBACK_EN
    logic [9:0] sat_q;
`endif

    // Input converted from offset binary to signed around midscale.
    assign x_calc = $signed({1'b0, data_in} - 11'(MID));

    // Echo term and saturating mix, evaluated while the RAM word is on ram_q (WAIT).
    always_comb begin
        m        = $signed(ram_q);
        e_shift  = m >>> ({1'b0, atten_q} + 3'd1);
        echo_on  = (delay_q != '0) && (fill >= delay_q);
        e        = echo_on ? e_shift : 10'sd0;
        sum      = {x_q[10], x_q} + {{2{e[9]}}, e};
        if (sum[11:9] == 3'b000 || sum[11:9] == 3'b111) begin
            sat = sum[9:0];
        end else if (sum[11]) begin
            sat = 10'h200;
        end else begin
            sat = 10'h1FF;
        end
        out_word = sat + 10'(MID);
    end

    // RAM port control: write only in WRITE, otherwise address the pending read.
    always_comb begin
        ram_we   = (state == WRITE);
        ram_addr = (state == WRITE) ? wr_ptr : rd_addr;
`ifdef ECHO_FEEDBACK_EN
        ram_wdat = sat_q;
`else
        ram_wdat = x_q[9:0];
`endif
    end

    // Buffer storage; no reset so it maps onto a block RAM.
    always_ff @(posedge sysclk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdat;
        end
        ram_q <= mem[ram_addr];
    end

    // FSM state register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: fixed five-cycle walk once a sample is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_valid) state_nxt = READ;
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = CALC;
            CALC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: accept-time latches, outputs, pointer and fill count.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            fill      <= '0;
            rd_addr   <= '0;
            delay_q   <= '0;
            atten_q   <= '0;
            x_q       <= '0;
            data_out  <= 10'(MID);
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef ECHO_FEEDBACK_EN
            sat_q     <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (data_valid && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (state == IDLE && data_valid) begin
                x_q     <= x_calc;
                delay_q <= delay;
                atten_q <= atten;
                rd_addr <= wr_ptr - delay;
            end
            // Registering at the WAIT->CALC edge makes the result visible during CALC.
            if (state == WAIT) begin
                data_out  <= out_word;
                out_valid <= 1'b1;
`ifdef ECHO_FEEDBACK_EN
                sat_q     <= sat;
`endif
            end
            if (state == WRITE) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != '1) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule
